rr_arb_sel_4: RTL

- Round-robin arbiter for four requesters; produces the 2-bit select that steers the downstream 4:1 data mux (4-bit data built from two 2-bit mux slices).
- Grants one source at a time and holds it for a bounded burst of transfers.
- Also produces a one-hot grant and a select-valid qualifier.
- Sits directly upstream of the mux: rr_arb_sel_4.sel drives the mux sel; sel_valid qualifies the mux output y.

---
 rtl/rr_arb_sel_4_if.sv | 26 ++
 rtl/rr_arb_sel_4.sv | 115 +++++++++++
 2 files changed

// File: rtl/rr_arb_sel_4_if.sv
// rtl/rr_arb_sel_4_if.sv - request/select bundle between requesters and the round-robin arbiter
interface rr_arb_sel_4_if;
    logic [3:0] req;
    logic       out_ready;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       sel_valid;

    // master: requester/downstream side that drives req and out_ready
    modport master (
        output req,
        output out_ready,
        input  gnt,
        input  sel,
        input  sel_valid
    );

    // slave: the arbiter itself
    modport slave (
        input  req,
        input  out_ready,
        output gnt,
        output sel,
        output sel_valid
    );
endinterface

// File: rtl/rr_arb_sel_4.sv
// rtl/rr_arb_sel_4.sv - four-way round-robin arbiter producing a bounded-burst mux select
module rr_arb_sel_4 #(
    parameter int MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           rst,
    rr_arb_sel_4_if.slave  bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic       sel_valid_q, sel_valid_d;

    logic       xfer;
    logic       release_grant;
    logic [1:0] arb_ptr;
    logic [1:0] scan_idx;
    logic [1:0] pick;
    logic       found;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 2'd0;
            cnt_q       <= 4'd0;
            gnt_q       <= 4'd0;
            sel_q       <= 2'd0;
            sel_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
        end
    end

    always_comb begin
        xfer          = 1'b0;
        release_grant = 1'b0;
        if (state_q == GRANT) begin
            xfer          = bus.out_ready && bus.req[sel_q];
            release_grant = !bus.req[sel_q] || (xfer && (cnt_q == LAST_BEAT));
        end
    end

    // On release the scan starts just past the released source, so it ends up lowest priority.
    always_comb begin
        arb_ptr  = (state_q == GRANT) ? (sel_q + 2'd1) : ptr_q;
        scan_idx = 2'd0;
        pick     = 2'd0;
        found    = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            scan_idx = arb_ptr + 2'(i);
            if (bus.req[scan_idx]) begin
                pick  = scan_idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        sel_d       = sel_q;
        sel_valid_d = sel_valid_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d     = GRANT;
                    gnt_d       = 4'b0001 << pick;
                    sel_d       = pick;
                    sel_valid_d = 1'b1;
                    cnt_d       = 4'd0;
                end
            end
            GRANT: begin
                if (release_grant) begin
                    ptr_d = sel_q + 2'd1;
                    cnt_d = 4'd0;
                    if (found) begin
                        gnt_d = 4'b0001 << pick;
                        sel_d = pick;
                    end else begin
                        // sel is left alone so the downstream mux does not toggle
                        state_d     = IDLE;
                        gnt_d       = 4'd0;
                        sel_valid_d = 1'b0;
                    end
                end else if (xfer) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;
    assign bus.sel_valid = sel_valid_q;
endmodule
